// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, models fixed latency, requests stalls.
// Build option: define MDU_DIV0_FAST_EN to retire divide-by-zero after a single busy cycle.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        int_req_i,
    input  logic [3:0]  op_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    output logic        busy_o,
    output logic        stall_req_o,
    output logic [31:0] mdu_out_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMfhi  = 4'd5;
    localparam logic [3:0] OpMflo  = 4'd6;
    localparam logic [3:0] OpMthi  = 4'd7;
    localparam logic [3:0] OpMtlo  = 4'd8;

    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        busy;
    logic        op_valid;
    logic        acc;

    logic        is_signed;
    logic [63:0] a_ext, b_ext, prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

    assign busy     = (cnt_q != 4'd0);
    assign op_valid = (op_i >= OpMult) && (op_i <= OpMtlo);
    assign acc      = op_valid && !busy && !int_req_i;

    assign busy_o      = busy;
    assign stall_req_o = busy && op_valid;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;

    always_comb begin
        mdu_out_o = 32'd0;
        if (op_i == OpMfhi) begin
            mdu_out_o = hi_q;
        end else if (op_i == OpMflo) begin
            mdu_out_o = lo_q;
        end
    end

    // Sign-extend only for the signed ops; the low 64 bits of the product are exact either way.
    always_comb begin
        is_signed = (op_i == OpMult) || (op_i == OpDiv);
        a_ext     = {{32{is_signed & rs_data_i[31]}}, rs_data_i};
        b_ext     = {{32{is_signed & rt_data_i[31]}}, rt_data_i};
        prod      = a_ext * b_ext;

        a_neg  = is_signed & rs_data_i[31];
        b_neg  = is_signed & rt_data_i[31];
        a_mag  = a_neg ? (32'd0 - rs_data_i) : rs_data_i;
        b_mag  = b_neg ? (32'd0 - rt_data_i) : rt_data_i;
        b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        // Magnitude form handles 0x8000_0000 / -1 naturally: quotient wraps back to 0x8000_0000.
        quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem    = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        if (busy) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else if (acc) begin
            case (op_i)
                OpMult, OpMultu: begin
                    pend_hi_d = prod[63:32];
                    pend_lo_d = prod[31:0];
                    cnt_d     = 4'(MULT_CYCLES);
                end
                OpDiv, OpDivu: begin
                    if (rt_data_i == 32'd0) begin
                        pend_hi_d = hi_q;
                        pend_lo_d = lo_q;
`ifdef MDU_DIV0_FAST_EN
                        cnt_d     = 4'd1;
`else
                        cnt_d     = 4'(DIV_CYCLES);
`endif
                    end else begin
                        pend_hi_d = rem;
                        pend_lo_d = quot;
                        cnt_d     = 4'(DIV_CYCLES);
                    end
                end
                OpMthi:  hi_d = rs_data_i;
                OpMtlo:  lo_d = rs_data_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q     <= 4'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: expected HI/LO pairs queued at issue, compared at commit.
module tb_mdu_ctrl;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;
`ifdef MDU_DIV0_FAST_EN
    localparam int DIV0_CYC = 1;
`else
    localparam int DIV0_CYC = DIV_CYC;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        int_req;
    logic [3:0]  op;
    logic [31:0] rs, rt;
    logic        busy, stall_req;
    logic [31:0] mdu_out, hi, lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] sb_q[$];
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    always #5 clk = ~clk;

    mdu_ctrl #(
        .MULT_CYCLES(MULT_CYC),
        .DIV_CYCLES (DIV_CYC)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .int_req_i  (int_req),
        .op_i       (op),
        .rs_data_i  (rs),
        .rt_data_i  (rt),
        .busy_o     (busy),
        .stall_req_o(stall_req),
        .mdu_out_o  (mdu_out),
        .hi_o       (hi),
        .lo_o       (lo)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference result as {hi, lo}; divide-by-zero keeps the current pair.
    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] h,
                                          input logic [31:0] l);
        logic signed [63:0] sa, sb, sp;
        logic signed [31:0] a32, b32, q32, r32;
        logic [63:0]        res;
        res = {h, l};
        case (o)
            4'd1: begin
                sa  = $signed({{32{a[31]}}, a});
                sb  = $signed({{32{b[31]}}, b});
                sp  = sa * sb;
                res = sp;
            end
            4'd2: res = {32'd0, a} * {32'd0, b};
            4'd3: begin
                if (b == 32'd0) begin
                    res = {h, l};
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    res = {32'd0, 32'h8000_0000};
                end else begin
                    a32 = a;
                    b32 = b;
                    q32 = a32 / b32;
                    r32 = a32 % b32;
                    res = {r32, q32};
                end
            end
            4'd4: res = (b == 32'd0) ? {h, l} : {a % b, a / b};
            default: res = {h, l};
        endcase
        return res;
    endfunction

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o;
        rs = a;
        rt = b;
        sb_q.push_back(model(o, a, b, model_hi, model_lo));
    endtask

    task automatic pop_check();
        logic [63:0] e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_empty: got 0 entries expected 1");
        end else begin
            e = sb_q.pop_front();
            check_eq("commit_hi", hi, e[63:32]);
            check_eq("commit_lo", lo, e[31:0]);
            model_hi = e[63:32];
            model_lo = e[31:0];
        end
    endtask

    // Called right after issue(); int_cyc pulses int_req in that busy cycle (0 = none).
    task automatic finish_op(input int exp_busy, input int int_cyc);
        int n;
        @(negedge clk);
        op = 4'hC;
        #1;
        check_eq("no_stall_op12", stall_req, 1'b0);
        op = 4'h0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            int_req = (n == int_cyc);
            @(negedge clk);
        end
        int_req = 1'b0;
        check_eq("busy_len", n, exp_busy);
        pop_check();
    endtask

    task automatic count_stall(input string tag, input int exp_n);
        int n;
        n = 0;
        #1;
        while (stall_req && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        check_eq(tag, n, exp_n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        int_req = 1'b0;
        op      = 4'd5;
        rs      = 32'd0;
        rt      = 32'd0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_stall", stall_req, 1'b0);
        check_eq("rst_hi", hi, 32'd0);
        check_eq("rst_lo", lo, 32'd0);
        check_eq("rst_mdu_out", mdu_out, 32'd0);
        reset = 1'b0;
        op    = 4'd0;

        issue(4'd1, 32'hFFFF_FFFF, 32'd2);
        finish_op(MULT_CYC, 0);
        issue(4'd2, 32'hFFFF_FFFF, 32'd2);
        finish_op(MULT_CYC, 0);

        // Interrupt blocks an otherwise acceptable MULT.
        @(negedge clk);
        op = 4'd1; rs = 32'd3; rt = 32'd4; int_req = 1'b1;
        @(negedge clk);
        check_eq("int_block_busy", busy, 1'b0);
        int_req = 1'b0;
        op = 4'd0;

        issue(4'd1, 32'd3, 32'd4);
        finish_op(MULT_CYC, 2);
        issue(4'd2, 32'h0001_0000, 32'h0003_0000);
        finish_op(MULT_CYC, MULT_CYC);

        // Back-to-back: second MULT held until the first retires.
        issue(4'd1, 32'h1234_5678, 32'd9);
        @(negedge clk);
        rs = 32'h8000_0000;
        rt = 32'h8000_0000;
        sb_q.push_back(model(4'd1, rs, rt, model_hi, model_lo));
        count_stall("b2b_stall", MULT_CYC);
        pop_check();
        finish_op(MULT_CYC, 0);

        // DIV then MFHI in the second busy cycle.
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        @(negedge clk);
        op = 4'd0;
        #1;
        check_eq("div_busy", busy, 1'b1);
        check_eq("div_nostall_none", stall_req, 1'b0);
        @(negedge clk);
        op = 4'd5;
        count_stall("mfhi_stall", DIV_CYC - 1);
        pop_check();
        check_eq("mfhi_out", mdu_out, model_hi);
        op = 4'd0;

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op(DIV_CYC, 0);
        issue(4'd4, 32'd100, 32'd7);
        finish_op(DIV_CYC, 0);
        issue(4'd3, 32'd7, 32'hFFFF_FFFE);
        finish_op(DIV_CYC, 0);

        // MTHI blocked by interrupt, then taken.
        @(negedge clk);
        op = 4'd7; rs = 32'h1234; int_req = 1'b1;
        @(negedge clk);
        check_eq("mthi_int_hi", hi, model_hi);
        int_req = 1'b0;
        @(negedge clk);
        model_hi = 32'h1234;
        check_eq("mthi_hi", hi, model_hi);
        check_eq("mthi_busy", busy, 1'b0);
        op = 4'd6;
        #1;
        check_eq("mflo_out", mdu_out, model_lo);

        // Divide by zero with HI/LO = 5/6.
        @(negedge clk);
        op = 4'd7; rs = 32'd5;
        @(negedge clk);
        op = 4'd8; rs = 32'd6;
        @(negedge clk);
        op = 4'd0;
        model_hi = 32'd5;
        model_lo = 32'd6;
        check_eq("mtlo_lo", lo, model_lo);
        issue(4'd3, 32'd77, 32'd0);
        finish_op(DIV0_CYC, 0);
        issue(4'd4, 32'd77, 32'd0);
        finish_op(DIV0_CYC, 0);

        // Asynchronous reset in busy cycle 4 of a DIVU.
        issue(4'd4, 32'd1000, 32'd3);
        void'(sb_q.pop_back());
        @(negedge clk);
        op = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("rstmid_busy", busy, 1'b0);
        check_eq("rstmid_hi", hi, 32'd0);
        check_eq("rstmid_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check_eq("rstmid_late_busy", busy, 1'b0);
        check_eq("rstmid_late_hi", hi, 32'd0);
        check_eq("rstmid_late_lo", lo, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Sequencer for the multiply/divide unit in the E stage. It accepts MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO operations from the E-stage instruction. It models the fixed multi-cycle latency with a countdown, owns the HI/LO registers, and raises a stall request while busy. Its `mdu_out` feeds the M pipeline register's `MDU_in`. An interrupt flush suppresses any new HI/LO side effect from the E-stage instruction.

## Interface
- `MULT_CYCLES`, 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `int_req` in 1: interrupt/exception flush; the E-stage op this cycle is discarded.
- `op` in 4: E-stage MDU op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO. Values 9–15 are treated as NONE.
- `rs_data` in 32: forwarded rs value.
- `rt_data` in 32: forwarded rt value.
- `busy` out 1: computation in flight.
- `stall_req` out 1: hold the E stage (freeze F/D/E, bubble into M).
- `mdu_out` out 32: MFHI→`hi`, MFLO→`lo`, otherwise 0. Combinational.
- `hi` out 32: architectural HI.
- `lo` out 32: architectural LO.

## Operation
- **State**
  - `cnt`: 4-bit down-counter, wide enough for `DIV_CYCLES ≤ 15`.
  - `pend_hi`, `pend_lo`: 32-bit pending results.
  - `hi`, `lo`.
  - States: IDLE (`cnt==0`) and BUSY (`cnt!=0`). `busy = (cnt!=0)`.
- **Accept condition:** `acc = (op in 1..8) && !busy && !int_req`. The op executes only on an accepting edge.
- **MULT/MULTU accepted**
  - Compute the 64-bit signed (MULT) or unsigned (MULTU) product of `rs_data`×`rt_data`.
  - `pend_hi` ← bits 63:32, `pend_lo` ← bits 31:0.
  - `cnt` ← `MULT_CYCLES`. IDLE→BUSY.
- **DIV/DIVU accepted**
  - Signed division truncates toward zero. The remainder takes the dividend's sign.
  - `pend_lo` ← quotient, `pend_hi` ← remainder.
  - `cnt` ← `DIV_CYCLES`.
  - Divisor 0: `pend_hi`/`pend_lo` ← the current `hi`/`lo`, so the architectural value is unchanged.
  - Signed 0x8000_0000 / 0xFFFF_FFFF: quotient 0x8000_0000, remainder 0.
- **BUSY**
  - `cnt` decrements each edge.
  - On the edge where `cnt` goes 1→0: `hi` ← `pend_hi`, `lo` ← `pend_lo`. BUSY→IDLE.
- **MTHI/MTLO accepted:** `hi` or `lo` ← `rs_data` on that edge. No busy period.
- **MFHI/MFLO:** read only. `mdu_out` reflects the current `hi`/`lo`.
- **Stall:** `stall_req = busy && (op in 1..8)`. Ops of 0 or 9–15 never stall.
- **int_req**
  - Blocks acceptance in its cycle.
  - Does not affect an in-flight computation: the issuing instruction is older than the interrupted one, so it completes and commits.
- **reset:** asynchronous. `cnt`=0, `pend_hi`=`pend_lo`=0, `hi`=`lo`=0.

## Timing
- **Outputs during reset:** `busy`=0, `stall_req`=0, `hi`=0, `lo`=0, `mdu_out`=0.
- **Multiply, accepted at edge T**
  - `busy`=1 during cycles T..T+4 (with `MULT_CYCLES`=5).
  - New `hi`/`lo` are visible from the cycle after T+4's closing edge, the first cycle with `busy`=0.
- **Back-to-back MULT:** the second op stalls for the full busy window. It is accepted in the first cycle with `busy`=0, giving a gap of exactly `MULT_CYCLES` cycles.
- **MFLO following MULT:** stalled until `busy`=0, then reads the new `lo` the same cycle (no extra bubble).
- **int_req with acc otherwise true:** no state change, `cnt` stays 0.
- **int_req in the final busy cycle:** the commit still happens.
- **reset asserted mid-BUSY:** aborts immediately. No commit occurs after reset releases.

## Configuration
- **Macro:** `MDU_DIV0_FAST_EN`.
  - Defined: DIV/DIVU with `rt_data`==0 loads `cnt` ← 1. The op completes, leaving HI/LO unchanged, after 1 busy cycle.
  - Undefined: divide-by-zero takes the full `DIV_CYCLES`.
  - All other behaviour is identical in both builds.

## Test plan
- **Reset, then MULT:** reset; MULT `rs`=0xFFFF_FFFF, `rt`=2 → `busy` for 5 cycles, then `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFFE. MULTU with the same operands → `hi`=1, `lo`=0xFFFF_FFFE.
- **DIV then MFHI:** DIV `rs`=-7 (0xFFFF_FFF9), `rt`=2; MFHI presented the next cycle → `stall_req`=1 for 9 cycles, then `lo`=0xFFFF_FFFD, `hi`=0xFFFF_FFFF, `mdu_out`=0xFFFF_FFFF.
- **MTHI under interrupt:** MTHI `rs`=0x1234 with `int_req`=1 → `hi` unchanged. Repeat with `int_req`=0 → `hi`=0x1234 on the next edge, `busy` stays 0.
- **Interrupt during busy:** MULT 3×4 accepted, `int_req` pulsed in busy cycle 2 → `lo`=12 committed on schedule.
- **Reset mid-DIV:** DIVU in flight, async `reset` at busy cycle 4 → `busy`, `hi`, `lo` = 0 immediately. No later commit.
- **Divide by zero:** DIV `rt`=0 with `hi`=5, `lo`=6 → `hi`/`lo` stay 5/6. `busy` lasts 10 cycles without `MDU_DIV0_FAST_EN` and 1 cycle with it.
